multdiv_sequencer: RTL
======================

# multdiv_sequencer

Multi-cycle signed multiply/divide controller that sequences the shared 32-bit ALU with a radix-2 iterative algorithm: shift-add for multiply, restoring division for divide. It sits beside the ALU in the execute stage. On a start pulse it owns the ALU operand/opcode lines for 32 iterations, then presents a 32-bit result with a one-cycle ready strobe. Sign handling, carry/borrow detection and result fix-up are internal; the ALU performs only the per-iteration 32-bit add or subtract.

## Interface
- No parameters; all datapaths are fixed at 32 bits, and the iteration count is fixed at 32.
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl_MULT  in  1  start-multiply pulse; sampled only in IDLE.
- ctrl_DIV  in  1  start-divide pulse; sampled only in IDLE.
- data_operandA  in  32  multiplicand / dividend (signed); latched on the start edge.
- data_operandB  in  32  multiplier / divisor (signed); latched on the start edge.
- data_result  out  32  product low word or quotient; holds its value until the next completion.
- data_exception  out  1  overflow or divide-by-zero flag for the current result; valid with data_resultRDY and held after it.
- data_resultRDY  out  1  one-cycle completion strobe.
- busy  out  1  high from the cycle after start until data_resultRDY is asserted.
- alu_operandA, alu_operandB  out  32  ALU operand drives.
- alu_opcode  out  5  ALU opcode: 00000 = add, 00001 = subtract.
- alu_shiftamt  out  5  constant 0.
- alu_result  in  32  ALU result; combinational return in the same cycle.

## Operation
- States: IDLE, RUN_MUL, RUN_DIV, FIXUP.
- IDLE transitions:
  - ctrl_MULT -> RUN_MUL. If both ctrl inputs are high, ctrl_MULT wins.
  - ctrl_DIV with data_operandB != 0 -> RUN_DIV.
  - ctrl_DIV with data_operandB == 0 -> FIXUP.
- Start edge actions:
  - Latch magA = |A| and magB = |B| as 32-bit unsigned values; |0x80000000| = 0x80000000.
  - Latch sign = A[31] ^ B[31].
  - Clear the 6-bit iteration counter.
- RUN_MUL (registers P_hi = 0 and P_lo = magB at start):
  - ALU drive: alu_operandA = P_hi, alu_operandB = magA, opcode add.
  - carry = (alu_result < P_hi), unsigned compare.
  - If P_lo[0] = 1: {P_hi, P_lo} <= {carry, alu_result, P_lo} >> 1.
  - Else: {P_hi, P_lo} <= {1'b0, P_hi, P_lo} >> 1.
- RUN_DIV (registers R = 0 and Q = magA at start):
  - Form {R', Q'} = {R, Q} << 1.
  - ALU drive: alu_operandA = R', alu_operandB = magB, opcode subtract.
  - If R' >= magB (unsigned): R <= alu_result, Q <= {Q'[31:1], 1}.
  - Else: R <= R', Q <= Q'.
- Counter and exit: the counter increments on every RUN edge. After the 32nd iteration the FSM moves to FIXUP; the remainder is discarded.
- FIXUP (one cycle), multiply: mag = {P_hi, P_lo}.
  - Result = low 32 bits of the signed product (mag negated if sign).
  - Exception if mag > 0x7FFFFFFF with sign = 0, or mag > 0x80000000 with sign = 1.
- FIXUP, divide: quotient truncates toward zero (Q negated if sign).
  - Exception with result 0x80000000 for A = 0x80000000, B = 0xFFFFFFFF.
  - Divide-by-zero: result 0, exception 1.
- FIXUP registers data_result and data_exception and raises data_resultRDY, then returns to IDLE.
- ALU drives outside RUN states: alu_operandA = alu_operandB = 0, alu_opcode = 00000.
- Start pulses while busy or in FIXUP are ignored; no queuing.

## Timing
- Reset (asynchronous assert, any state):
  - FSM to IDLE and counter cleared.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
  - ALU drives return to zero / add.
  - An in-flight operation is abandoned and no data_resultRDY is issued.
- Start on edge 0. Iterations occur on edges 1..32; FIXUP is on edge 33.
- data_resultRDY is high from edge 33 to edge 34, a latency of 33 cycles. busy is high from edge 0 to edge 33.
- Divide-by-zero: FIXUP on edge 1, data_resultRDY high for the cycle after edge 1.
- A new start is accepted on the edge at which data_resultRDY is high, since the FSM is back in IDLE. Back-to-back operations therefore have a 34-cycle period.
- The ALU is purely combinational; operand drives are stable for the whole of each RUN cycle.

## Test plan
- MULT 6 × 7 -> data_resultRDY 33 cycles after start; result 42; exception 0; busy low afterwards.
- MULT −3 × 5 -> 0xFFFFFFF1, exception 0. MULT 0x10000 × 0x10000 -> result 0, exception 1. MULT 0x80000000 × 1 -> 0x80000000, exception 0.
- DIV 100 / 7 -> 14; DIV −100 / 7 -> −14 (0xFFFFFFF2); DIV 7 / 100 -> 0; all exception 0.
- DIV 5 / 0 -> result 0, exception 1, data_resultRDY one cycle after start. DIV 0x80000000 / −1 -> 0x80000000, exception 1.
- ctrl_MULT and ctrl_DIV high together (3, 4) -> 12. ctrl_DIV pulse mid-run -> ignored, current result unaffected. Back-to-back start on the data_resultRDY edge -> accepted.
- reset_n low at iteration 10 -> all outputs 0 immediately, no data_resultRDY. After release, MULT 2 × 3 -> 6.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//
// Multi-cycle signed 32-bit multiply/divide controller.  A start pulse in IDLE
// takes over the shared ALU for 32 radix-2 iterations: shift-add for
// multiply and restoring division for divide.  The ALU only does the
// per-iteration add or subtract.  Sign handling, carry detection and the
// final negation / overflow check are done here.
//
// Ports
//   clock           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   ctrl_MULT       start-multiply pulse (sampled in IDLE, wins over ctrl_DIV)
//   ctrl_DIV        start-divide pulse (sampled in IDLE)
//   data_operandA   multiplicand / dividend (signed), latched on start
//   data_operandB   multiplier / divisor (signed), latched on start
//   data_result     product low word or quotient, held until next completion
//   data_exception  overflow / divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY  one-cycle completion strobe
//   busy            high from the start edge until data_resultRDY rises
//   alu_operandA/B  ALU operand drives (zero outside the RUN states)
//   alu_opcode      00000 = add, 00001 = subtract
//   alu_shiftamt    always zero
//   alu_result      combinational ALU result
//   dbg_state       current FSM state for checkers
//
// Handshake: a start pulse is consumed on the rising edge at which the FSM is
// in IDLE; pulses in any other state are dropped, never queued.  The result is
// qualified by data_resultRDY for exactly one cycle and held afterwards.

module multdiv_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN_MUL = 2'd1,
        S_RUN_DIV = 2'd2,
        S_FIXUP   = 2'd3
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] mag_a_q;
    logic [31:0] mag_b_q;
    logic        sign_q;
    logic        op_div_q;
    // Multiply: acc_hi = P_hi, acc_lo = P_lo.  Divide: acc_hi = R, acc_lo = Q.
    logic [31:0] acc_hi_q;
    logic [31:0] acc_lo_q;
    logic [31:0] acc_hi_d;
    logic [31:0] acc_lo_d;

    // Magnitudes of the incoming operands; 0x80000000 maps onto itself,
    // which is exactly its unsigned magnitude.
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    assign abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // Divide: {R, Q} shifted left by one.  R < magB <= 2^31 so R' fits in 32 bits.
    logic [31:0] rem_sh;
    logic [31:0] quo_sh;
    assign rem_sh = {acc_hi_q[30:0], acc_lo_q[31]};
    assign quo_sh = {acc_lo_q[30:0], 1'b0};

    // Multiply: P_hi + magA wrapped if the sum is smaller than P_hi.
    logic mul_carry;
    assign mul_carry = (alu_result < acc_hi_q);

    always_comb begin
        alu_operandA = 32'd0;
        alu_operandB = 32'd0;
        alu_opcode   = OP_ADD;
        case (state_q)
            S_RUN_MUL: begin
                alu_operandA = acc_hi_q;
                alu_operandB = mag_a_q;
                alu_opcode   = OP_ADD;
            end
            S_RUN_DIV: begin
                alu_operandA = rem_sh;
                alu_operandB = mag_b_q;
                alu_opcode   = OP_SUB;
            end
            default: ;
        endcase
    end

    assign alu_shiftamt = 5'd0;
    assign dbg_state    = state_q;

    always_comb begin
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        case (state_q)
            S_RUN_MUL: begin
                if (acc_lo_q[0]) begin
                    {acc_hi_d, acc_lo_d} = {mul_carry, alu_result, acc_lo_q[31:1]};
                end else begin
                    {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[31:1]};
                end
            end
            S_RUN_DIV: begin
                if (rem_sh >= mag_b_q) begin
                    acc_hi_d = alu_result;
                    acc_lo_d = {quo_sh[31:1], 1'b1};
                end else begin
                    acc_hi_d = rem_sh;
                    acc_lo_d = quo_sh;
                end
            end
            default: ;
        endcase
    end

    // Result fix-up, evaluated during the FIXUP cycle.
    logic [63:0] mul_mag;
    logic [31:0] mul_res;
    logic        mul_exc;
    logic        div_zero;
    logic [31:0] div_res;
    logic        div_exc;

    assign mul_mag  = {acc_hi_q, acc_lo_q};
    assign mul_res  = sign_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
    assign mul_exc  = sign_q ? (mul_mag > 64'h0000_0000_8000_0000)
                             : (mul_mag > 64'h0000_0000_7FFF_FFFF);
    assign div_zero = (mag_b_q == 32'd0);
    // A positive quotient with bit 31 set only arises from 0x80000000 / -1.
    assign div_res  = div_zero ? 32'd0 : (sign_q ? (~acc_lo_q + 32'd1) : acc_lo_q);
    assign div_exc  = div_zero | (~sign_q & acc_lo_q[31]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 6'd0;
            mag_a_q        <= 32'd0;
            mag_b_q        <= 32'd0;
            sign_q         <= 1'b0;
            op_div_q       <= 1'b0;
            acc_hi_q       <= 32'd0;
            acc_lo_q       <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ctrl_MULT || ctrl_DIV) begin
                        mag_a_q  <= abs_a;
                        mag_b_q  <= abs_b;
                        sign_q   <= data_operandA[31] ^ data_operandB[31];
                        cnt_q    <= 6'd0;
                        acc_hi_q <= 32'd0;
                        busy     <= 1'b1;
                        if (ctrl_MULT) begin
                            op_div_q <= 1'b0;
                            acc_lo_q <= abs_b;
                            state_q  <= S_RUN_MUL;
                        end else begin
                            op_div_q <= 1'b1;
                            acc_lo_q <= abs_a;
                            state_q  <= (data_operandB == 32'd0) ? S_FIXUP : S_RUN_DIV;
                        end
                    end
                end
                S_RUN_MUL, S_RUN_DIV: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    data_result    <= op_div_q ? div_res : mul_res;
                    data_exception <= op_div_q ? div_exc : mul_exc;
                    data_resultRDY <= 1'b1;
                    busy           <= 1'b0;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
